// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: machine word, opcode field, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  // Bubble word inserted into IF/ID when no real instruction is latched.
  localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for {instr, pc4} captured while IF/ID is stalled.
// Latency: loaded value visible one cycle after load_i.
// Backpressure: none; the owner never loads while valid_o is set.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  word_t instr_q;
  word_t pc4_q;
  logic  valid_q;

  // Clear wins over load so a squash in the same cycle leaves the entry empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; PC, iREN/ihit handshake, stall buffering, redirect, halt.
// Latency: fetched word appears in IF/ID one cycle after ihit (or on stall release via hold buffer).
// Backpressure: stall holds IF/ID; a word arriving under stall parks in a 1-entry buffer and REN drops.
// Optional macro FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_IF_ID,
  output logic [5:0]  opcode_IF_ID,
  output logic [5:0]  func_IF_ID,
  output logic [15:0] imm16_IF_ID,
  output logic [31:0] pc4_IF_ID,
  output logic        valid_IF_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        pc4_q, pc4_d;
  logic         valid_q, valid_d;
  word_t        pc_plus4;

  logic         hb_load;
  logic         hb_clear;
  word_t        hb_instr;
  word_t        hb_pc4;
  logic         hb_valid;

  // Wraps modulo 2^32; no alignment check.
  assign pc_plus4 = pc_q + 32'd4;

  fetch_hold_buf u_hold_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (hb_load),
    .clear_i (hb_clear),
    .instr_i (imemload),
    .pc4_i   (pc_plus4),
    .instr_o (hb_instr),
    .pc4_o   (hb_pc4),
    .valid_o (hb_valid)
  );

  // Next-state: redirect beats halt beats normal fetch/hold/halted behaviour.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;

    if (redirect_en && (state_q != HALTED)) begin
      // Squash regardless of stall; any ihit data this cycle is dropped.
      pc_d     = redirect_pc;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
      hb_clear = 1'b1;
      state_d  = FETCH;
    end else if (halt) begin
      state_d  = HALTED;
      hb_clear = 1'b1;
      if (!stall) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit && !stall) begin
            instr_d = imemload;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else if (ihit) begin
            // ID is stalled: park the word and stop requesting until it drains.
            hb_load = 1'b1;
            pc_d    = pc_plus4;
            state_d = HOLD;
          end else if (!stall) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d  = hb_instr;
            pc4_d    = hb_pc4;
            valid_d  = hb_valid;
            hb_clear = 1'b1;
            state_d  = FETCH;
          end
        end
        HALTED: begin
          if (!stall) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and IF/ID register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imemaddr     = pc_q;
  assign imemREN      = (state_q == FETCH) && !RST;
  assign instr_IF_ID  = instr_q;
  assign opcode_IF_ID = opcode_t'(instr_q[31:26]);
  assign func_IF_ID   = instr_q[5:0];
  assign imm16_IF_ID  = instr_q[15:0];
  assign pc4_IF_ID    = pc4_q;
  assign valid_IF_ID  = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count accepted fetches and non-halted stall cycles; both wrap naturally.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == FETCH) && ihit && !redirect_en && !halt)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && (state_q != HALTED))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model + expected-instruction queue.
// Latency: one cycle per stimulus step.
// Backpressure: driven through the stall input.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_IF_ID;
  logic [5:0]  opcode_IF_ID;
  logic [5:0]  func_IF_ID;
  logic [15:0] imm16_IF_ID;
  logic [31:0] pc4_IF_ID;
  logic        valid_IF_ID;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .imemload     (imemload),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .instr_IF_ID  (instr_IF_ID),
    .opcode_IF_ID (opcode_IF_ID),
    .func_IF_ID   (func_IF_ID),
    .imm16_IF_ID  (imm16_IF_ID),
    .pc4_IF_ID    (pc4_IF_ID),
    .valid_IF_ID  (valid_IF_ID)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;

  fetch_state_t m_state;
  logic [31:0]  m_pc;
  logic [31:0]  m_instr;
  logic [31:0]  m_pc4;
  logic         m_valid;
  exp_t         m_hb;
  logic [31:0]  m_fcnt;
  logic [31:0]  m_scnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0;
    redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(posedge CLK); #1;
    chk("rst_ren",   {31'd0, imemREN},     32'd0);
    chk("rst_addr",  imemaddr,             32'h0);
    chk("rst_instr", instr_IF_ID,          NOP);
    chk("rst_pc4",   pc4_IF_ID,            32'h0);
    chk("rst_valid", {31'd0, valid_IF_ID}, 32'd0);
    RST = 1'b0;
    m_state = FETCH; m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_hb = '0; m_fcnt = '0; m_scnt = '0;
    sb.delete();
  endtask

  // One clock of stimulus; model predicts, queue carries the expected IF/ID word.
  task automatic cyc(input logic h, input logic [31:0] d, input logic s,
                     input logic re, input logic [31:0] rp, input logic hl);
    logic upd;
    logic push;
    exp_t e;
    ihit = h; imemload = d; stall = s; redirect_en = re; redirect_pc = rp; halt = hl;
    upd = 1'b0; push = 1'b0;
    if (m_state == FETCH && h && !re && !hl) m_fcnt = m_fcnt + 1;
    if (s && m_state != HALTED) m_scnt = m_scnt + 1;
    if (m_state != HALTED && re) begin
      m_pc = rp; m_state = FETCH; upd = 1'b1;
    end else if (hl) begin
      m_state = HALTED; upd = !s;
    end else begin
      case (m_state)
        FETCH: begin
          if (h && !s) begin
            sb.push_back('{instr: d, pc4: m_pc + 32'd4});
            push = 1'b1; upd = 1'b1; m_pc = m_pc + 32'd4;
          end else if (h) begin
            m_hb = '{instr: d, pc4: m_pc + 32'd4};
            m_pc = m_pc + 32'd4; m_state = HOLD;
          end else begin
            upd = !s;
          end
        end
        HOLD: begin
          if (!s) begin
            sb.push_back(m_hb); push = 1'b1; upd = 1'b1; m_state = FETCH;
          end
        end
        default: upd = !s;
      endcase
    end
    @(posedge CLK); #1;
    if (upd) begin
      if (push && sb.size() > 0) begin
        e = sb.pop_front();
        m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    chk("addr",   imemaddr,                      m_pc);
    chk("ren",    {31'd0, imemREN},              {31'd0, (m_state == FETCH)});
    chk("instr",  instr_IF_ID,                   m_instr);
    chk("pc4",    pc4_IF_ID,                     m_pc4);
    chk("valid",  {31'd0, valid_IF_ID},          {31'd0, m_valid});
    chk("opcode", {26'd0, opcode_IF_ID},         {26'd0, m_instr[31:26]});
    chk("func",   {26'd0, func_IF_ID},           {26'd0, m_instr[5:0]});
    chk("imm16",  {16'd0, imm16_IF_ID},          {16'd0, m_instr[15:0]});
  endtask

  initial begin
    do_reset();

`ifdef FETCH_PERF_EN
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fetch_count5", fetch_count, 32'd5);
    chk("stall_count2", stall_count, 32'd2);
    do_reset();
`endif

    // Straight-line fetch from PC 0.
    chk("addr0", imemaddr, 32'h0);
    cyc(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("tp_opcode", {26'd0, opcode_IF_ID}, 32'h08);
    chk("tp_imm16",  {16'd0, imm16_IF_ID},  32'h0005);
    chk("tp_pc4",    pc4_IF_ID,             32'h4);
    cyc(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("tp_addr8", imemaddr, 32'h8);

    // Stall with data arriving at PC 8: park, hold 3 cycles, release.
    cyc(1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("hold_ren",  {31'd0, imemREN}, 32'd0);
    chk("hold_pc",   imemaddr,         32'hC);
    chk("hold_keep", pc4_IF_ID,        32'h8);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rel_instr", instr_IF_ID,          32'h0000_0020);
    chk("rel_func",  {26'd0, func_IF_ID},  32'h20);
    chk("rel_pc4",   pc4_IF_ID,            32'hC);
    chk("rel_ren",   {31'd0, imemREN},     32'd1);

    // Redirect with simultaneous ihit: data dropped.
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    chk("redir_addr",  imemaddr,             32'h100);
    chk("redir_valid", {31'd0, valid_IF_ID}, 32'd0);

    // Redirect while in HOLD: parked word must never surface.
    cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold_drop", instr_IF_ID, 32'hAAAA_0001);

    // PC wrap at the top of the address space.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 32'h0BAD_0001, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc4", pc4_IF_ID, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0, 32'h0, 1'b0);

    // Halt at PC 16: sticky, ignores redirect, cleared by reset.
    chk("pre_halt_pc", imemaddr, 32'h10);
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_ren",   {31'd0, imemREN},     32'd0);
    chk("halt_pc",    imemaddr,             32'h10);
    chk("halt_valid", {31'd0, valid_IF_ID}, 32'd0);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    chk("halt_noredir", imemaddr, 32'h10);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (m_state == HALTED && $urandom_range(0, 3) == 0) do_reset();
      cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 39) == 0);
    end

`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fcnt);
    chk("stall_count", stall_count, m_scnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register. It drives the instruction-memory request and produces the opcode_IF_ID, func_IF_ID and imm16 fields that the control unit decodes.
- Holds the PC and handles the iREN/ihit handshake.
- Buffers one instruction that arrives during a stall.
- Applies redirects and halt from later stages.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  synchronous reset, active-high.
ihit  input  1  instruction memory data valid this cycle.
imemload  input  32  instruction word from memory.
imemREN  output  1  instruction read request.
imemaddr  output  32  fetch address (= PC).
stall  input  1  hazard unit: hold IF/ID.
redirect_en  input  1  branch/jump taken: load redirect_pc, squash.
redirect_pc  input  32  target address.
halt  input  1  control unit halt decoded in ID.
instr_IF_ID  output  32  latched instruction.
opcode_IF_ID  output  6  instr_IF_ID[31:26].
func_IF_ID  output  6  instr_IF_ID[5:0].
imm16_IF_ID  output  16  instr_IF_ID[15:0].
pc4_IF_ID  output  32  fetch address of latched instruction + 4.
valid_IF_ID  output  1  latched instruction is real (not a bubble).

Behaviour:
- Synchronous active-high reset, one clock domain (CLK).
- Reset values:
  - PC=PC_INIT, state=FETCH.
  - instr_IF_ID=NOP_WORD, pc4_IF_ID=0, valid_IF_ID=0.
  - Hold buffer cleared.
  - imemREN=0 while RST is high.
- Field outputs are combinational slices of instr_IF_ID.
- imemaddr=PC always. imemREN=(state==FETCH)&~RST.
- States are FETCH, HOLD and HALTED. Update priority per cycle is RST > redirect_en > halt > normal.
- FETCH:
  - ihit&~stall: IF/ID<={imemload, PC+4, valid=1}; PC<=PC+4.
  - ihit&stall: hold buffer<={imemload, PC+4}; PC<=PC+4; IF/ID unchanged; go to HOLD.
  - ~ihit&~stall: IF/ID<=bubble (NOP_WORD, valid=0, pc4 unchanged).
  - ~ihit&stall: everything holds.
- HOLD:
  - imemREN=0; PC holds.
  - ~stall: IF/ID<=hold buffer, valid=1; go to FETCH.
  - stall: remain in HOLD.
- redirect_en (any state except HALTED):
  - PC<=redirect_pc.
  - IF/ID<=bubble, even if stall is high.
  - Hold buffer discarded; go to FETCH.
  - Data arriving with ihit in the same cycle is discarded.
- halt:
  - Go to HALTED.
  - Data arriving with ihit in the same cycle is discarded.
  - The hold buffer is discarded.
- HALTED:
  - Sticky until RST; imemREN=0; PC frozen.
  - IF/ID<=bubble whenever ~stall.
  - redirect_en is ignored.
- PC arithmetic is 32-bit modulo: PC+4 from 32'hFFFF_FFFC wraps to 0. No alignment check.
- The hold buffer is one entry deep. It is never overwritten because imemREN=0 in HOLD.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every accepted ihit (FETCH & ihit & ~redirect_en & ~halt).
  - stall_count increments on every cycle with stall=1 and state!=HALTED.
  - Both counters wrap at 2^32.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- fetch_state_t (FETCH, HOLD, HALTED) goes in data_path_muxs_pkg alongside the existing mux selection enums.
- word_t and opcode_t come from cpu_types_pkg; NOP_WORD's default comes from there.
- A matching fetch_stage_if interface with modport fs mirrors the existing interface style.
- One sub-module, fetch_hold_buf: a 1-entry register of {instr, pc4} with load/clear/valid.

Test Plan:
- Reset then ihit=1 with imemload=32'h2008_0005 for 3 cycles, stall=0:
  - imemaddr goes 0,4,8.
  - instr_IF_ID=32'h2008_0005, opcode_IF_ID=6'h08, imm16_IF_ID=16'h0005, pc4_IF_ID=4, valid=1.
- ihit=1 with stall=1 at PC=8, imemload=32'h0000_0020:
  - Goes to HOLD; imemREN=0; PC=12; IF/ID unchanged.
  - Stall held 3 cycles, then released: IF/ID=32'h0000_0020, func=6'h20, pc4=12, valid=1; back in FETCH.
- redirect_en=1, redirect_pc=32'h0000_0100, with ihit=1 in the same cycle:
  - Next cycle: imemaddr=32'h100, valid_IF_ID=0, instr_IF_ID=NOP_WORD.
- redirect_en asserted while in HOLD:
  - Hold buffer dropped; PC=redirect_pc; the held instruction never appears.
- halt=1 at PC=16:
  - imemREN=0 thereafter; PC stays 16; valid_IF_ID=0.
  - A later redirect_en has no effect; RST returns PC to 0.
- With FETCH_PERF_EN defined, 5 accepted fetches and 2 stall cycles -> fetch_count=5, stall_count=2.
